pipelined_tree_adder: RTL and testbench
=======================================

Name: pipelined_tree_adder

Overview:
- Registered, backpressure-aware reduction adder. Sums SIZE operands of WIDTH bits into one full-precision result.
- One pipeline register per tree level; accepts one operand vector per cycle at full throughput.
- Successor to the combinational recursive tree adder, with these additions:
  - arbitrary (non-power-of-two) SIZE
  - carry-preserving output width
  - signed/unsigned mode
  - valid/ready flow control
- Sits between parallel datapath producers (e.g. dot-product multipliers) and a downstream consumer that may stall.

Parameters:
- WIDTH, 8: bit width of each input operand.
- SIZE, 5: number of operands; any integer >= 1.
- SIGNED, 0: 0 = operands unsigned (zero-extend); 1 = operands two's complement (sign-extend).
- OUT_WIDTH, WIDTH+clog2(SIZE): derived, must not be overridden; result width, overflow-free.
- LATENCY, max(1, clog2(SIZE)): derived; cycles from accepted input to valid output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data_in holds a valid operand vector.
- in_ready  out  1  block can accept data_in this cycle.
- data_in  in  SIZE*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  data_out holds a valid sum.
- out_ready  in  1  consumer accepts data_out this cycle.
- data_out  out  OUT_WIDTH  sum of all SIZE operands.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - all stage valid bits clear, so out_valid = 0.
  - data_out = 0 and all stage data registers = 0.
  - in_ready = 1 from the first cycle after reset release.
- Width extension: each operand is extended to OUT_WIDTH before any addition (zero- or sign-extend per SIGNED). All adds are OUT_WIDTH wide; no overflow is possible.
- Level structure: level L has N_L entries, with N_0 = SIZE and N_{L+1} = ceil(N_L/2).
  - Pair i adds entries 2i and 2i+1.
  - If N_L is odd, the last entry passes through unchanged (no zero-add needed).
  - Every level's outputs are registered.
- SIZE = 1 edge case: a single registered pass-through stage (LATENCY = 1), data_out = extended operand 0.
- Flow control: global pipeline enable, adv = !out_valid || out_ready.
  - in_ready = adv (combinational; no combinational path from in_valid to in_ready).
  - When adv = 1, every stage loads from the previous one. Stage 0 valid bit loads in_valid && in_ready.
  - When adv = 0, every stage holds; data_out and out_valid are stable while out_valid && !out_ready.
- Bubbles: invalid stages still shift when adv = 1. Data registers of invalid stages may hold stale values; only valid-bit semantics matter.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: results leave in acceptance order; none is dropped or duplicated.
- Latency: the sum of a vector accepted on cycle T appears with out_valid = 1 on cycle T+LATENCY, provided out_ready was 1 throughout.
- Simultaneous events: out_ready = 1 with a full pipeline accepts a new input the same cycle (pop and push together).
- Reset mid-operation: all in-flight vectors are discarded immediately; no partial result is ever presented after reset.

Decomposition:
- Package tree_adder_pkg:
  - function clog2 (integer ceiling log2, with clog2(1) = 0).
  - function level_count(size, level) returning N_L.
  - localparam helper for OUT_WIDTH.
- Sub-module tree_adder_level (params IN_COUNT, W): one combinational pairwise-add level with odd pass-through, plus its valid/data register gated by adv.
- The top generates LATENCY instances of tree_adder_level and owns the handshake logic.

Test Plan:
- Reset check:
  - Hold rst_n = 0 and drive in_valid = 1 -> out_valid = 0, data_out = 0, no output for LATENCY+2 cycles.
  - Release -> in_ready = 1.
- Unsigned max, SIZE = 5, WIDTH = 8:
  - Input all operands 255 -> data_out = 1275 (11'h4FB) exactly 3 cycles later; OUT_WIDTH = 11.
- Signed, SIZE = 4, WIDTH = 8, SIGNED = 1:
  - Input {-128, -128, 127, 1} -> data_out = -128 (10'h380) after 2 cycles.
  - Input all -128 -> data_out = -512 (10'h200).
- Streaming:
  - Drive vectors whose sums are 0..19 back-to-back with out_ready = 1 -> 20 consecutive out_valid cycles, values 0..19 in order.
- Backpressure:
  - Stream as above with out_ready toggled pseudo-randomly.
  - Required: data_out stable while stalled, no loss or duplication, in_ready = 0 exactly when out_valid = 1 and out_ready = 0.
- SIZE = 1 and async reset mid-stream:
  - SIZE = 1, input 8'hA5 -> data_out = 8'hA5 after 1 cycle.
  - Assert rst_n low with 3 vectors in flight -> out_valid drops in the same cycle; after release, no stale results appear.

Source files
------------

// File: rtl/tree_adder_pkg.sv
// Shared sizing helpers for the pipelined reduction adder.
// All functions are elaboration-time only.
package tree_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SIZE  = 5;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Entry count at a given tree level: halves (rounding up) per level.
    function automatic int level_count(input int size, input int level);
        int n;
        n = size;
        for (int l = 0; l < level; l++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic int out_width(input int width, input int size);
        return width + clog2(size);
    endfunction

    function automatic int latency(input int size);
        return (clog2(size) < 1) ? 1 : clog2(size);
    endfunction

endpackage

// File: rtl/tree_adder_level.sv
// One reduction level: pairwise adds with odd pass-through,
// followed by a valid/data register that advances on adv.
module tree_adder_level #(
    parameter int IN_COUNT = 2,
    parameter int W        = 8,
    parameter int OC       = (IN_COUNT + 1) / 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
    input  logic                in_valid,
    input  logic [IN_COUNT*W-1:0] in_data,
    output logic                out_valid,
    output logic [OC*W-1:0]     out_data
);

    logic [OC*W-1:0] sum;

    for (genvar i = 0; i < IN_COUNT / 2; i++) begin : g_pair
        assign sum[i*W +: W] = in_data[(2*i)*W +: W]
                             + in_data[(2*i+1)*W +: W];
    end

    if ((IN_COUNT % 2) != 0) begin : g_odd
        assign sum[(OC-1)*W +: W] = in_data[(IN_COUNT-1)*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= sum;
        end
    end

endmodule

// File: rtl/pipelined_tree_adder.sv
// Registered valid/ready reduction adder: sums SIZE operands into
// one overflow-free result, one tree level per pipeline stage.
module pipelined_tree_adder
    import tree_adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SIZE      = DEFAULT_SIZE,
    parameter int SIGNED    = 0,
    parameter int OUT_WIDTH = out_width(WIDTH, SIZE),
    parameter int LATENCY   = latency(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  data_out
);

    logic                      adv;
    logic [SIZE*OUT_WIDTH-1:0] ext;

    // Single global enable: the whole pipe moves unless the head is stuck.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SIZE; k++) begin : g_ext
        if (SIGNED != 0) begin : g_sx
            assign ext[k*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'(signed'(data_in[k*WIDTH +: WIDTH]));
        end else begin : g_zx
            assign ext[k*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'(data_in[k*WIDTH +: WIDTH]);
        end
    end

    for (genvar l = 0; l < LATENCY; l++) begin : g_lvl
        localparam int NI = level_count(SIZE, l);
        localparam int NO = level_count(SIZE, l + 1);

        logic                   v_in;
        logic [NI*OUT_WIDTH-1:0] d_in;
        logic                   v_out;
        logic [NO*OUT_WIDTH-1:0] d_out;

        if (l == 0) begin : g_head
            assign v_in = in_valid && in_ready;
            assign d_in = ext;
        end else begin : g_body
            assign v_in = g_lvl[l-1].v_out;
            assign d_in = g_lvl[l-1].d_out;
        end

        tree_adder_level #(
            .IN_COUNT (NI),
            .W        (OUT_WIDTH),
            .OC       (NO)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_data  (d_out)
        );
    end

    assign out_valid = g_lvl[LATENCY-1].v_out;
    assign data_out  = g_lvl[LATENCY-1].d_out;

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// Scoreboard bench for pipelined_tree_adder across three
// configurations: 5x8 unsigned, 4x8 signed, 1x8 pass-through.
module tb_pipelined_tree_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [39:0] a_di;
    logic [10:0] a_do;

    logic        b_iv, b_ir, b_ov, b_or;
    logic [31:0] b_di;
    logic [9:0]  b_do;

    logic        c_iv, c_ir, c_ov, c_or;
    logic [7:0]  c_di;
    logic [7:0]  c_do;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] q_a[$];
    logic [9:0]  q_b[$];

    pipelined_tree_adder #(.WIDTH(8), .SIZE(5), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .data_in(a_di),
        .out_valid(a_ov), .out_ready(a_or), .data_out(a_do)
    );

    pipelined_tree_adder #(.WIDTH(8), .SIZE(4), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .data_in(b_di),
        .out_valid(b_ov), .out_ready(b_or), .data_out(b_do)
    );

    pipelined_tree_adder #(.WIDTH(8), .SIZE(1), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_iv), .in_ready(c_ir), .data_in(c_di),
        .out_valid(c_ov), .out_ready(c_or), .data_out(c_do)
    );

    function automatic logic [10:0] model_sum5(input logic [39:0] v);
        logic [10:0] s;
        s = '0;
        for (int k = 0; k < 5; k++) s = s + 11'(v[k*8 +: 8]);
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_iv = 1'b1; a_di = '1; a_or = 1'b1;
        b_iv = 1'b0; b_di = '0; b_or = 1'b1;
        c_iv = 1'b0; c_di = '0; c_or = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            n_cmp++;
            if (a_ov !== 1'b0 || a_do !== 11'h000) begin
                n_bad++;
                $display("FAIL reset_hold out_valid=%b data_out=%h want 0/000",
                         a_ov, a_do);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_iv = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (a_ir !== 1'b1 || a_ov !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0",
                     a_ir, a_ov);
        end
    endtask

    task automatic test_unsigned_max();
        @(negedge clk);
        a_or = 1'b1; a_iv = 1'b1; a_di = {5{8'hFF}};
        #1;
        n_cmp++;
        if (a_ir !== 1'b1) begin
            n_bad++;
            $display("FAIL umax_in_ready got=%b want 1", a_ir);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1;
            n_cmp++;
            if (k == 3) begin
                if (a_ov !== 1'b1 || a_do !== 11'h4FB) begin
                    n_bad++;
                    $display("FAIL umax_result k=%0d valid=%b data=%h want 1/4fb",
                             k, a_ov, a_do);
                end
            end else if (a_ov !== 1'b0) begin
                n_bad++;
                $display("FAIL umax_latency k=%0d valid=%b want 0", k, a_ov);
            end
        end
    endtask

    task automatic test_signed();
        logic [9:0] e;
        b_or = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b_iv = 1'b1; b_di = {8'h80, 8'h80, 8'h7F, 8'h01};
                e = 10'h380;
            end else if (k == 1) begin
                b_iv = 1'b1; b_di = {4{8'h80}};
                e = 10'h200;
            end else begin
                b_iv = 1'b0;
            end
            #1;
            if (b_iv && b_ir) q_b.push_back(e);
            n_cmp++;
            if ((k == 2 || k == 3) !== (b_ov === 1'b1)) begin
                n_bad++;
                $display("FAIL signed_latency k=%0d valid=%b", k, b_ov);
            end
            if (b_ov && b_or) begin
                n_cmp++;
                if (q_b.size() == 0) begin
                    n_bad++;
                    $display("FAIL signed_extra data=%h want none", b_do);
                end else begin
                    e = q_b.pop_front();
                    if (b_do !== e) begin
                        n_bad++;
                        $display("FAIL signed_value got=%h want %h", b_do, e);
                    end
                end
            end
        end
    endtask

    task automatic test_streaming();
        int sent, got, first, last, rem, x;
        logic [10:0] e;
        sent = 0; got = 0; first = -1; last = -1;
        a_or = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            @(negedge clk);
            if (sent < 20) begin
                rem = sent;
                for (int k = 0; k < 4; k++) begin
                    x = $urandom_range(0, rem);
                    a_di[k*8 +: 8] = 8'(x);
                    rem = rem - x;
                end
                a_di[32 +: 8] = 8'(rem);
                a_iv = 1'b1;
            end else begin
                a_iv = 1'b0;
            end
            #1;
            if (a_iv && a_ir) begin
                q_a.push_back(11'(sent));
                sent++;
            end
            if (a_ov && a_or) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_cmp++;
                e = (q_a.size() != 0) ? q_a.pop_front() : 11'h7FF;
                if (a_do !== e) begin
                    n_bad++;
                    $display("FAIL stream_value idx=%0d got=%0d want=%0d",
                             got, a_do, e);
                end
                got++;
            end
        end
        a_iv = 1'b0;
        n_cmp++;
        if (got != 20 || last - first != 19) begin
            n_bad++;
            $display("FAIL stream_count got=%0d span=%0d want 20/19",
                     got, last - first);
        end
    endtask

    task automatic test_backpressure();
        int sent, got;
        logic prev_stall;
        logic [10:0] prev_do, e;
        logic [39:0] cur;
        sent = 0; got = 0; prev_stall = 1'b0; prev_do = '0;
        cur = {$urandom(), 8'($urandom())};
        for (int cyc = 0; cyc < 600 && got < 60; cyc++) begin
            @(negedge clk);
            a_or = 1'($urandom_range(0, 1));
            a_iv = (sent < 60) && ($urandom_range(0, 3) != 0);
            a_di = cur;
            #1;
            n_cmp++;
            if (a_ir !== !(a_ov && !a_or)) begin
                n_bad++;
                $display("FAIL bp_in_ready got=%b valid=%b ready=%b",
                         a_ir, a_ov, a_or);
            end
            if (prev_stall) begin
                n_cmp++;
                if (a_ov !== 1'b1 || a_do !== prev_do) begin
                    n_bad++;
                    $display("FAIL bp_stable valid=%b data=%h want 1/%h",
                             a_ov, a_do, prev_do);
                end
            end
            if (a_iv && a_ir) begin
                q_a.push_back(model_sum5(cur));
                sent++;
                cur = {$urandom(), 8'($urandom())};
            end
            if (a_ov && a_or) begin
                n_cmp++;
                e = (q_a.size() != 0) ? q_a.pop_front() : 11'h7FF;
                if (a_do !== e) begin
                    n_bad++;
                    $display("FAIL bp_value idx=%0d got=%h want=%h",
                             got, a_do, e);
                end
                got++;
            end
            prev_stall = a_ov && !a_or;
            prev_do = a_do;
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        n_cmp++;
        if (got != 60 || q_a.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count got=%0d left=%0d want 60/0",
                     got, q_a.size());
        end
    endtask

    task automatic test_size1();
        c_or = 1'b1;
        @(negedge clk);
        c_iv = 1'b1; c_di = 8'hA5;
        @(negedge clk);
        c_iv = 1'b0; c_di = 8'h00;
        #1;
        n_cmp++;
        if (c_ov !== 1'b1 || c_do !== 8'hA5) begin
            n_bad++;
            $display("FAIL size1_value valid=%b data=%h want 1/a5", c_ov, c_do);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (c_ov !== 1'b0) begin
            n_bad++;
            $display("FAIL size1_drain valid=%b want 0", c_ov);
        end
    endtask

    task automatic test_async_reset();
        a_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_iv = 1'b1;
            a_di = {8'(k), 8'(k), 8'h10, 8'h20, 8'h30};
        end
        @(negedge clk);
        a_iv = 1'b0;
        #1;
        n_cmp++;
        if (a_ov !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_inflight valid=%b want 1", a_ov);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_ov !== 1'b0 || a_do !== 11'h000) begin
            n_bad++;
            $display("FAIL ar_drop valid=%b data=%h want 0/000", a_ov, a_do);
        end
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        a_or = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            n_cmp++;
            if (a_ov !== 1'b0) begin
                n_bad++;
                $display("FAIL ar_stale valid=%b data=%h want 0", a_ov, a_do);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_streaming();
        test_backpressure();
        test_size1();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
